// File: rtl/configurable_mult_seq_pkg.sv
// Shared types and lane-geometry helpers for the lane-configurable sequential multiplier.
// Lanes are always counted in quarters of DATA_W, so every mode maps onto the same four slots.
package cfg_mult_pkg;

  typedef enum logic [1:0] {
    MODE_4X = 2'b00,
    MODE_2X = 2'b01,
    MODE_1X = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_e;

  function automatic mode_e decode_mode(logic [1:0] cm);
    case (cm)
      2'b00:   return MODE_4X;
      2'b01:   return MODE_2X;
      default: return MODE_1X;
    endcase
  endfunction

  function automatic int lane_width(mode_e mode, int data_w);
    case (mode)
      MODE_4X: return data_w / 4;
      MODE_2X: return data_w / 2;
      default: return data_w;
    endcase
  endfunction

  // Bit i kills the carry out of product quarter i into quarter i+1 when that is a lane edge.
  function automatic logic [2:0] lane_mask(mode_e mode, int data_w);
    logic [2:0] m;
    m = '0;
    for (int i = 0; i < 3; i++) begin
      m[i] = (((i + 1) * (data_w / 4)) % lane_width(mode, data_w)) == 0;
    end
    return m;
  endfunction

endpackage

// File: rtl/configurable_mult_seq_if.sv
// Operand-issue and result handshake bundle of the configurable multiplier.
// The slave side is the multiplier; the master side is the issue logic plus result FIFO.
interface configurable_mult_seq_if #(
  parameter int DATA_W = 16
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [DATA_W-1:0]     multiplicand_i;
  logic [DATA_W-1:0]     multiplier_i;
  logic [1:0]            cm_i;
  logic                  signed_i;
  logic [2*DATA_W-1:0]   product_o;
  logic                  out_valid_o;
  logic                  out_ready_i;

  modport master (
    output in_valid_i, multiplicand_i, multiplier_i, cm_i, signed_i, out_ready_i,
    input  in_ready_o, product_o, out_valid_o
  );

  modport slave (
    input  in_valid_i, multiplicand_i, multiplier_i, cm_i, signed_i, out_ready_i,
    output in_ready_o, product_o, out_valid_o
  );
endinterface

// File: rtl/configurable_mult_seq_partitioned_adder.sv
// 2*DATA_W adder built from four quarter adders; kill[i] blocks the carry from quarter i to i+1.
module partitioned_adder #(
  parameter int DATA_W = 16
) (
  input  logic [2*DATA_W-1:0] a,
  input  logic [2*DATA_W-1:0] b,
  input  logic [2:0]          kill,
  output logic [2*DATA_W-1:0] sum
);
  localparam int S = DATA_W / 2;

  logic [2:0] co;

  for (genvar q = 0; q < 4; q++) begin : g_q
    if (q == 0) begin : g_lo
      assign {co[0], sum[S-1:0]} = {1'b0, a[S-1:0]} + {1'b0, b[S-1:0]};
    end else if (q == 3) begin : g_hi
      assign sum[3*S +: S] = a[3*S +: S] + b[3*S +: S]
                           + {{(S-1){1'b0}}, co[2] & ~kill[2]};
    end else begin : g_mid
      assign {co[q], sum[q*S +: S]} = {1'b0, a[q*S +: S]} + {1'b0, b[q*S +: S]}
                                    + {{S{1'b0}}, co[q-1] & ~kill[q-1]};
    end
  end
endmodule

// File: rtl/configurable_mult_seq.sv
// Lane-configurable sequential shift-add multiplier (1x DATA_W, 2x DATA_W/2 or 4x DATA_W/4).
// state   | meaning
// IDLE    | in_ready high, waiting for operands
// CALC    | one shift-add iteration per enabled cycle, L iterations total
// DONE    | out_valid high, product held until out_ready
module configurable_mult_seq
  import cfg_mult_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input logic                    clk_i,
  input logic                    reset_ni,
  input logic                    enable_i,
  configurable_mult_seq_if.slave bus
);
  localparam int Q  = DATA_W / 4;
  localparam int S  = DATA_W / 2;
  localparam int PW = 2 * DATA_W;
  localparam int CW = $clog2(DATA_W);

  state_e            state;
  mode_e             mode;
  logic [3:0]        neg;
  logic [PW-1:0]     a_sh, acc, product_q;
  logic [DATA_W-1:0] b_sh;
  logic [CW-1:0]     counter;
  logic              in_ready_q, out_valid_q;

  mode_e             mode_in;
  logic [3:0]        sgn_a, sgn_b;
  logic [DATA_W-1:0] a_abs, b_abs;
  logic [PW-1:0]     a_wide, addend, inv, ones, acc_sum, neg_sum;
  logic [3:0]        q_sel, q_neg, q_base;
  logic [2:0]        kill;
  logic              last;

  assign mode_in = decode_mode(bus.cm_i);

  // Magnitudes are formed at accept; each |A| lane is placed at the low half of its 2L product slot.
  always_comb begin
    sgn_a  = '0;
    sgn_b  = '0;
    a_abs  = bus.multiplicand_i;
    b_abs  = bus.multiplier_i;
    a_wide = '0;
    case (mode_in)
      MODE_4X: for (int k = 0; k < 4; k++) begin
        sgn_a[k] = bus.signed_i & bus.multiplicand_i[k*Q+Q-1];
        sgn_b[k] = bus.signed_i & bus.multiplier_i[k*Q+Q-1];
        if (sgn_a[k]) a_abs[k*Q +: Q] = -bus.multiplicand_i[k*Q +: Q];
        if (sgn_b[k]) b_abs[k*Q +: Q] = -bus.multiplier_i[k*Q +: Q];
        a_wide[k*S +: Q] = a_abs[k*Q +: Q];
      end
      MODE_2X: for (int k = 0; k < 2; k++) begin
        sgn_a[k] = bus.signed_i & bus.multiplicand_i[k*S+S-1];
        sgn_b[k] = bus.signed_i & bus.multiplier_i[k*S+S-1];
        if (sgn_a[k]) a_abs[k*S +: S] = -bus.multiplicand_i[k*S +: S];
        if (sgn_b[k]) b_abs[k*S +: S] = -bus.multiplier_i[k*S +: S];
        a_wide[k*DATA_W +: S] = a_abs[k*S +: S];
      end
      default: begin
        sgn_a[0] = bus.signed_i & bus.multiplicand_i[DATA_W-1];
        sgn_b[0] = bus.signed_i & bus.multiplier_i[DATA_W-1];
        if (sgn_a[0]) a_abs = -bus.multiplicand_i;
        if (sgn_b[0]) b_abs = -bus.multiplier_i;
        a_wide[DATA_W-1:0] = a_abs;
      end
    endcase
  end

  // Map each product quarter to its lane: multiplier bit, sign, and whether it is the lane LSB.
  always_comb begin
    q_sel  = '0;
    q_neg  = '0;
    q_base = '0;
    for (int q = 0; q < 4; q++) begin
      case (mode)
        MODE_4X: begin
          q_sel[q]  = b_sh[q*Q];
          q_neg[q]  = neg[q];
          q_base[q] = 1'b1;
        end
        MODE_2X: begin
          q_sel[q]  = b_sh[(q/2)*S];
          q_neg[q]  = neg[q/2];
          q_base[q] = (q % 2) == 0;
        end
        default: begin
          q_sel[q]  = b_sh[0];
          q_neg[q]  = neg[0];
          q_base[q] = q == 0;
        end
      endcase
    end
  end

  always_comb begin
    addend = '0;
    inv    = '0;
    ones   = '0;
    for (int q = 0; q < 4; q++) begin
      addend[q*S +: S] = q_sel[q] ? a_sh[q*S +: S] : '0;
      inv[q*S +: S]    = {S{q_neg[q]}};
      ones[q*S +: S]   = {{(S-1){1'b0}}, q_base[q] & q_neg[q]};
    end
  end

  assign kill = lane_mask(mode, DATA_W);
  assign last = counter == CW'(lane_width(mode, DATA_W) - 1);

  partitioned_adder #(.DATA_W(DATA_W)) u_acc (
    .a    (acc),
    .b    (addend),
    .kill (kill),
    .sum  (acc_sum)
  );

  // Lane-wise two's complement of the final sum: invert negative lanes, add 1 at their LSB.
  partitioned_adder #(.DATA_W(DATA_W)) u_neg (
    .a    (acc_sum ^ inv),
    .b    (ones),
    .kill (kill),
    .sum  (neg_sum)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= ST_IDLE;
      mode        <= MODE_4X;
      neg         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      acc         <= '0;
      counter     <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid_i) begin
            mode       <= mode_in;
            neg        <= sgn_a ^ sgn_b;
            a_sh       <= a_wide;
            b_sh       <= b_abs;
            acc        <= '0;
            counter    <= '0;
            in_ready_q <= 1'b0;
            state      <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (enable_i) begin
            a_sh    <= a_sh << 1;
            b_sh    <= b_sh >> 1;
            acc     <= acc_sum;
            counter <= counter + CW'(1);
            if (last) begin
              product_q   <= neg_sum;
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.product_o   = product_q;
endmodule

// File: tb/tb_configurable_mult_seq.sv
// Directed bench for configurable_mult_seq at DATA_W=16 with an arithmetic per-lane reference model.
module tb_configurable_mult_seq;
  logic        clk;
  logic        reset_n;
  logic        enable;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_prod = '0;
  bit          pending = 0;

  configurable_mult_seq_if #(.DATA_W(16)) bus ();

  configurable_mult_seq #(.DATA_W(16)) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .enable_i (enable),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: split into lanes, multiply as plain integers, keep the low 2L bits of each.
  function automatic logic [31:0] model(logic [15:0] a, logic [15:0] b, logic [1:0] cm, logic sg);
    int L, n;
    longint x, y, p, m1, m2;
    logic [31:0] r;
    L  = (cm == 2'b00) ? 4 : (cm == 2'b01) ? 8 : 16;
    n  = 16 / L;
    m1 = (longint'(1) << L) - 1;
    m2 = (longint'(1) << (2 * L)) - 1;
    r  = '0;
    for (int k = 0; k < n; k++) begin
      x = longint'(a >> (k * L)) & m1;
      y = longint'(b >> (k * L)) & m1;
      if (sg && x[L-1]) x = x - (longint'(1) << L);
      if (sg && y[L-1]) y = y - (longint'(1) << L);
      p = x * y;
      r = r | (32'(p & m2) << (2 * L * k));
    end
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    if (reset_n && bus.out_valid_o) begin
      if (!pending) check32("unexpected_valid", {31'b0, bus.out_valid_o}, 32'd0);
      else          check32("model_cmp", bus.product_o, exp_prod);
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] cm,
                        input logic sg, input logic [31:0] lit, input int lat,
                        input int stall_k, input int hold);
    int  t0, k;
    bit  seen;
    k = 0;
    while (!bus.in_ready_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    check32("ready_before_op", {31'b0, bus.in_ready_o}, 32'd1);
    bus.multiplicand_i = a;
    bus.multiplier_i   = b;
    bus.cm_i           = cm;
    bus.signed_i       = sg;
    bus.out_ready_i    = (hold == 0);
    bus.in_valid_i     = 1'b1;
    exp_prod           = model(a, b, cm, sg);
    pending            = 1'b1;
    @(negedge clk);
    t0 = cyc;
    bus.in_valid_i   = 1'b0;
    bus.cm_i         = ~cm;
    bus.signed_i     = ~sg;
    bus.multiplicand_i = ~a;
    check32("busy_ready_low", {31'b0, bus.in_ready_o}, 32'd0);
    seen = 0;
    k = 0;
    while (!seen && k < 300) begin
      if (bus.out_valid_o) seen = 1;
      else begin
        enable = !(stall_k >= 0 && (cyc - t0) >= stall_k && (cyc - t0) < stall_k + 3);
        @(negedge clk);
        k++;
      end
    end
    enable = 1'b1;
    check32("valid_seen", {31'b0, seen}, 32'd1);
    check32("latency", 32'(cyc - t0), 32'(lat));
    check32("product_lit", bus.product_o, lit);
    for (int i = 0; i < hold; i++) begin
      bus.in_valid_i     = (i % 2) == 0;
      bus.multiplicand_i = 16'h1234;
      @(negedge clk);
      check32("hold_valid", {31'b0, bus.out_valid_o}, 32'd1);
      check32("hold_product", bus.product_o, lit);
      check32("hold_ready_low", {31'b0, bus.in_ready_o}, 32'd0);
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    check32("valid_dropped", {31'b0, bus.out_valid_o}, 32'd0);
    check32("ready_back", {31'b0, bus.in_ready_o}, 32'd1);
    pending = 1'b0;
  endtask

  initial begin
    int t0;
    reset_n            = 1'b0;
    enable             = 1'b1;
    bus.in_valid_i     = 1'b0;
    bus.multiplicand_i = '0;
    bus.multiplier_i   = '0;
    bus.cm_i           = 2'b00;
    bus.signed_i       = 1'b0;
    bus.out_ready_i    = 1'b1;
    repeat (2) @(negedge clk);
    check32("rst_ready", {31'b0, bus.in_ready_o}, 32'd1);
    check32("rst_valid", {31'b0, bus.out_valid_o}, 32'd0);
    check32("rst_product", bus.product_o, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    check32("model_pin_1x", model(16'h9B4B, 16'hD1B9, 2'b10, 1'b0), 32'h7F387433);
    check32("model_pin_2xs", model(16'h80FF, 16'h8002, 2'b01, 1'b1), 32'h4000FFFE);
    check32("model_pin_4xs", model(16'h7F81, 16'h3C2D, 2'b00, 1'b1), 32'h1504F0FD);

    run_op(16'h9B4B, 16'hD1B9, 2'b10, 1'b0, 32'h7F387433, 16, -1, 0);
    run_op(16'h9B4B, 16'hD1B9, 2'b01, 1'b0, 32'h7E8B3633, 8, -1, 0);
    run_op(16'hFFFF, 16'hFFFF, 2'b00, 1'b0, 32'hE1E1E1E1, 4, -1, 0);
    run_op(16'h80FF, 16'h8002, 2'b01, 1'b1, 32'h4000FFFE, 8, -1, 0);
    run_op(16'hFFFF, 16'h0003, 2'b10, 1'b1, 32'hFFFFFFFD, 16, -1, 0);
    run_op(16'h9B4B, 16'hD1B9, 2'b11, 1'b0, 32'h7F387433, 16, -1, 0);
    run_op(16'h9B4B, 16'hD1B9, 2'b01, 1'b0, 32'h7E8B3633, 11, 2, 0);
    run_op(16'hFFFF, 16'hFFFF, 2'b00, 1'b0, 32'hE1E1E1E1, 4, -1, 5);
    enable = 1'b0;
    run_op(16'h8080, 16'h8080, 2'b01, 1'b1, 32'h40004000, 8, -1, 0);

    // Abort a long operation with reset in CALC, then check nothing stale escapes.
    bus.multiplicand_i = 16'h9B4B;
    bus.multiplier_i   = 16'hD1B9;
    bus.cm_i           = 2'b10;
    bus.signed_i       = 1'b0;
    bus.in_valid_i     = 1'b1;
    @(negedge clk);
    t0 = cyc;
    bus.in_valid_i = 1'b0;
    while (cyc - t0 < 4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check32("midrst_product", bus.product_o, 32'd0);
    check32("midrst_valid", {31'b0, bus.out_valid_o}, 32'd0);
    check32("midrst_ready", {31'b0, bus.in_ready_o}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check32("no_stale_valid", {31'b0, bus.out_valid_o}, 32'd0);
    end
    run_op(16'h7F81, 16'h3C2D, 2'b00, 1'b1, 32'h1504F0FD, 4, -1, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/configurable_mult_seq.md
# configurable_mult_seq

Parametrised, sequential, lane-configurable integer multiplier; next generation of the team's configurable multiplication block. One DATA_W×DATA_W product, two parallel (DATA_W/2)² products or four parallel (DATA_W/4)² products, signed or unsigned, computed by a shared radix-2 shift-add datapath with lane-partitioned carries. Sits between the operand-issue logic and the result FIFO, with valid/ready handshakes on both sides and a global enable_i stall.

## Interface
- DATA_W, 16: operand width; multiple of 4, ≥ 8.
- clk_i  in  1  clock, rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  global stall; low freezes the CALC iteration.
- in_valid_i  in  1  operand request.
- in_ready_o  out  1  block can accept operands.
- multiplicand_i  in  DATA_W  operand A, lanes packed LSB-first.
- multiplier_i  in  DATA_W  operand B, lanes packed LSB-first.
- cm_i  in  2  mode: 00 = 4 lanes of DATA_W/4; 01 = 2 lanes of DATA_W/2; 10 = 1 lane of DATA_W; 11 = treated as 10.
- signed_i  in  1  1 = two's-complement operands per lane.
- product_o  out  2*DATA_W  lane k product at bits [2L·k +: 2L], L = lane width.
- out_valid_o  out  1  product_o is valid.
- out_ready_i  in  1  consumer takes product.

## Operation
- States: IDLE → CALC → DONE → IDLE.
- IDLE: in_ready_o=1. in_valid_i & in_ready_o → latch cm_i, signed_i, per-lane |A|, |B| and per-lane result sign (sign_a XOR sign_b when signed); counter=0; → CALC.
- CALC: in_ready_o=0. Each cycle with enable_i=1 performs one iteration on all lanes in parallel: if bit 0 of the lane's B shift register is set, add the lane's A<<counter into the lane accumulator; shift B right; counter++. With enable_i=0, all state holds.
- The iteration in which counter reaches L-1 writes the final accumulator; negative-sign lanes are two's-complemented within 2L bits; → DONE.
- DONE: out_valid_o=1, product_o stable. out_ready_i=1 → IDLE. New operands are not accepted in DONE.
- Carries never cross lane boundaries; 2L-bit lane results are exact, no overflow (−2^(L−1)·−2^(L−1) = 2^(2L−2) fits).
- cm_i/signed_i changes after acceptance are ignored.
- Operand lanes unused in the selected mode: not applicable; every mode uses the full DATA_W.

## Timing
- Reset (async, any state): state=IDLE, in_ready_o=1, out_valid_o=0, product_o=0, counter=0, all operand registers 0.
- Accept at edge T → out_valid_o high after edge T+L (+1 per enable_i-low cycle in CALC). L = DATA_W/4, DATA_W/2, DATA_W for modes 00, 01, 10.
- in_ready_o rises on the edge after the out_valid_o & out_ready_i handshake; throughput = one operation per L+2 cycles with no stalls.
- out_ready_i already high on entry to DONE: out_valid_o is high for exactly one cycle.
- in_valid_i while busy: ignored; the source holds operands until in_ready_o.
- enable_i low in IDLE or DONE has no effect; handshakes still complete.
- Reset asserted mid-CALC or mid-DONE: result discarded, no out_valid_o pulse after release.

## Structure
- Package cfg_mult_pkg: mode enum (MODE_4X, MODE_2X, MODE_1X), state enum, function lane_width(mode, DATA_W), function lane_mask(mode, DATA_W) giving carry-kill boundaries.
- Sub-module partitioned_adder: a 2·DATA_W adder with a per-boundary carry-kill mask, used for accumulation and for the lane-wise negate.

## Test plan
- DATA_W=16, mode 10, unsigned, A=0x9B4B, B=0xD1B9 → product_o=0x7F387433, out_valid_o 16 cycles after accept.
- Mode 01, unsigned, same operands → product_o=0x7E8B3633, latency 8.
- Mode 00, unsigned, A=B=0xFFFF → product_o=0xE1E1E1E1, latency 4, no carry leakage between lanes.
- Mode 01, signed, A=0x80FF, B=0x8002 → product_o=0x4000FFFE; mode 10 signed, A=0xFFFF, B=0x0003 → 0xFFFFFFFD.
- Stalls: mode 01, enable_i low for 3 cycles mid-CALC → valid at 11 cycles. out_ready_i held low 5 cycles → product_o stable, in_ready_o=0 throughout, in_valid_i pulses ignored.
- Reset pulse at CALC cycle 4, then a fresh mode 00 operation → outputs 0 during reset, no stale valid, correct new result.
